// File: rtl/perm_scheduler_pkg.sv
// perm_scheduler_pkg: shared scheduler state enum, default widths and pointer wrap helper
package perm_scheduler_pkg;
  localparam int CWIDTH_DEF = 320;
  localparam int RWIDTH_DEF = 32;
  localparam int ROUNDS_DEF = 10;
  localparam int NREQ_DEF = 3;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} sched_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/perm_scheduler_if.sv
// perm_scheduler_if: requester bundle (req/req_c/req_rounds in, gnt/rsp_valid/rsp_c/rsp_r/rsp_err out) with master=requester, slave=scheduler
interface perm_scheduler_if
  import perm_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int RWIDTH = RWIDTH_DEF,
  parameter int ROUND_COUNT = ROUNDS_DEF
);
  logic [NREQ-1:0] req;
  logic [NREQ*CWIDTH-1:0] req_c;
  logic [NREQ*ROUND_COUNT-1:0] req_rounds;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_valid;
  logic [CWIDTH-1:0] rsp_c;
  logic [RWIDTH-1:0] rsp_r;
  logic rsp_err;
  modport master (output req, req_c, req_rounds, input gnt, rsp_valid, rsp_c, rsp_r, rsp_err);
  modport slave (input req, req_c, req_rounds, output gnt, rsp_valid, rsp_c, rsp_r, rsp_err);
endinterface

// File: rtl/perm_scheduler_rr_arbiter.sv
// perm_scheduler_rr_arbiter: combinational round-robin pick from ptr (req, ptr in; one-hot gnt_next, idx_next out)
module perm_scheduler_rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_next,
  output logic [PW-1:0]   idx_next
);
  logic [PW-1:0] j;
  always_comb begin
    gnt_next = '0;
    idx_next = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt_next = NREQ'(1) << j;
        idx_next = j;
      end
    end
  end
endmodule

// File: rtl/perm_scheduler.sv
// perm_scheduler: round-robin share of one G core (clk, reset, rq slave bundle, busy/timeout_err status, p_* G launch/result port)
module perm_scheduler
  import perm_scheduler_pkg::*;
#(
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int RWIDTH = RWIDTH_DEF,
  parameter int ROUND_COUNT = ROUNDS_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  perm_scheduler_if.slave        rq,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   p_reset,
  output logic                   p_en,
  output logic [CWIDTH-1:0]      p_c,
  output logic [ROUND_COUNT-1:0] p_rounds,
  input  logic [CWIDTH-1:0]      p_cout,
  input  logic [RWIDTH-1:0]      p_rout,
  input  logic                   p_done
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  sched_state_t state;
  logic [PW-1:0] ptr, idx, idx_next;
  logic [NREQ-1:0] gnt, gnt_next, rsp_valid;
  logic [CWIDTH-1:0] rsp_c;
  logic [RWIDTH-1:0] rsp_r;
  logic rsp_err;
  logic [TW-1:0] cnt;
  logic fin;
  perm_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(rq.req),
    .ptr(ptr),
    .gnt_next(gnt_next),
    .idx_next(idx_next)
  );
  assign rq.gnt = gnt;
  assign rq.rsp_valid = rsp_valid;
  assign rq.rsp_c = rsp_c;
  assign rq.rsp_r = rsp_r;
  assign rq.rsp_err = rsp_err;
  assign busy = state != IDLE;
  assign fin = p_done | (cnt == TLIM);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_c <= '0;
      rsp_r <= '0;
      rsp_err <= 1'b0;
      timeout_err <= 1'b0;
      p_reset <= 1'b1;
      p_en <= 1'b0;
      p_c <= '0;
      p_rounds <= '0;
      cnt <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (|rq.req) begin
          state <= LAUNCH;
          gnt <= gnt_next;
          idx <= idx_next;
          p_c <= rq.req_c[idx_next*CWIDTH +: CWIDTH];
          p_rounds <= rq.req_rounds[idx_next*ROUND_COUNT +: ROUND_COUNT];
          cnt <= '0;
        end
        LAUNCH: begin
          state <= RUN;
          p_reset <= 1'b0;
          p_en <= 1'b1;
        end
        RUN: begin
          cnt <= (cnt == TLIM) ? cnt : cnt + 1'b1;
          // p_done takes priority over a watchdog expiring in the same cycle
          if (fin) begin
            state <= RESP;
            p_reset <= 1'b1;
            p_en <= 1'b0;
            rsp_valid <= gnt;
            rsp_c <= p_done ? p_cout : '0;
            rsp_r <= p_done ? p_rout : '0;
            rsp_err <= !p_done;
            timeout_err <= timeout_err | !p_done;
          end
        end
        default: begin
          state <= IDLE;
          gnt <= '0;
          ptr <= PW'(wrap_inc(int'(idx), NREQ));
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perm_scheduler.sv
// tb_perm_scheduler: directed checks of arbitration, latency, watchdog and reset for perm_scheduler
module tb_perm_scheduler;
  localparam int N = 3;
  localparam int CW = 320;
  localparam int RW = 32;
  localparam int RC = 10;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, timeout_err, p_reset, p_en, p_done;
  logic [CW-1:0] p_c, p_cout;
  logic [RC-1:0] p_rounds;
  logic [RW-1:0] p_rout;
  logic never_done = 1'b0;
  int gcnt = 0;
  int errors = 0;
  int checks = 0;
  perm_scheduler_if #(.NREQ(N), .CWIDTH(CW), .RWIDTH(RW), .ROUND_COUNT(RC)) rq ();
  perm_scheduler #(.CWIDTH(CW), .RWIDTH(RW), .ROUND_COUNT(RC), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rq(rq.slave), .busy(busy), .timeout_err(timeout_err),
    .p_reset(p_reset), .p_en(p_en), .p_c(p_c), .p_rounds(p_rounds),
    .p_cout(p_cout), .p_rout(p_rout), .p_done(p_done)
  );
  always #5 clk = ~clk;
  // G model: done in the (rounds+1)-th enabled cycle, cout = c + rounds, rout = c[31:0] ^ A5A5A5A5
  always @(posedge clk) gcnt <= p_reset ? 0 : (p_en ? gcnt + 1 : gcnt);
  assign p_done = p_en && !never_done && gcnt == int'(p_rounds);
  assign p_cout = p_c + CW'(p_rounds);
  assign p_rout = p_c[RW-1:0] ^ 32'hA5A5_A5A5;
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end
  task automatic set_op(input int i, input logic [CW-1:0] c, input logic [RC-1:0] r);
    rq.req_c[i*CW +: CW] = c;
    rq.req_rounds[i*RC +: RC] = r;
  endtask
  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rq.gnt == '0 && cyc < 40);
    if (rq.gnt == '0) cyc = -1;
  endtask
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rq.rsp_valid == '0 && cyc < 60);
    if (rq.rsp_valid == '0) cyc = -1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({rq.gnt, rq.rsp_valid, rq.rsp_err} !== 7'b0) begin errors++; $display("FAIL rst_gnt_rsp: got %0h expected 0", {rq.gnt, rq.rsp_valid, rq.rsp_err}); end
    checks++; if ({rq.rsp_c, rq.rsp_r} !== '0) begin errors++; $display("FAIL rst_rsp_data: got %0h expected 0", {rq.rsp_c, rq.rsp_r}); end
    checks++; if ({busy, timeout_err, p_reset, p_en} !== 4'b0010) begin errors++; $display("FAIL rst_status: got %b expected 0010", {busy, timeout_err, p_reset, p_en}); end
    checks++; if ({p_c, p_rounds} !== '0) begin errors++; $display("FAIL rst_operands: got %0h expected 0", {p_c, p_rounds}); end
    reset = 1'b0;
  endtask
  task automatic test_single();
    int cyc;
    set_op(1, 1, 10);
    rq.req = 3'b010;
    @(negedge clk);
    checks++; if (rq.gnt !== 3'b010) begin errors++; $display("FAIL t1_gnt: got %b expected 010", rq.gnt); end
    checks++; if ({busy, p_reset, p_en} !== 3'b110) begin errors++; $display("FAIL t1_launch: got %b expected 110", {busy, p_reset, p_en}); end
    checks++; if (p_c !== CW'(1) || p_rounds !== 10'd10) begin errors++; $display("FAIL t1_latch: got %0h/%0d expected 1/10", p_c, p_rounds); end
    @(negedge clk);
    checks++; if ({p_reset, p_en} !== 2'b01) begin errors++; $display("FAIL t1_run: got %b expected 01", {p_reset, p_en}); end
    wait_rsp(cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL t1_latency: got %0d expected 11", cyc); end
    checks++; if (rq.rsp_valid !== 3'b010 || rq.rsp_err !== 1'b0) begin errors++; $display("FAIL t1_rsp: got %b/%b expected 010/0", rq.rsp_valid, rq.rsp_err); end
    checks++; if (rq.rsp_c !== CW'(11) || rq.rsp_r !== 32'hA5A5_A5A4) begin errors++; $display("FAIL t1_data: got %0h/%0h expected b/a5a5a5a4", rq.rsp_c, rq.rsp_r); end
    rq.req = '0;
    @(negedge clk);
    checks++; if ({rq.rsp_valid, rq.gnt, busy} !== 7'b0) begin errors++; $display("FAIL t1_strobe_once: got %b expected 0", {rq.rsp_valid, rq.gnt, busy}); end
  endtask
  task automatic test_round_robin();
    int cyc;
    logic [N-1:0] e;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, CW'(100 + i), 1);
    rq.req = 3'b111;
    for (int j = 0; j < 6; j++) begin
      e = 3'(1 << (j % 3));
      wait_gnt(cyc);
      checks++; if (rq.gnt !== e) begin errors++; $display("FAIL t2_order%0d: got %b expected %b", j, rq.gnt, e); end
      wait_rsp(cyc);
      checks++; if (rq.rsp_valid !== e || rq.rsp_c !== CW'(101 + j % 3)) begin errors++; $display("FAIL t2_rsp%0d: got %b/%0d expected %b/%0d", j, rq.rsp_valid, rq.rsp_c, e, 101 + j % 3); end
      if (j == 5) rq.req = '0;
    end
    @(negedge clk);
  endtask
  task automatic test_pulse();
    int cyc;
    logic seen;
    set_op(0, 7, 5);
    rq.req = 3'b001;
    wait_gnt(cyc);
    checks++; if (rq.gnt !== 3'b001) begin errors++; $display("FAIL t3_gnt0: got %b expected 001", rq.gnt); end
    repeat (2) @(negedge clk);
    rq.req = 3'b101;
    set_op(0, 99, 1);
    @(negedge clk);
    rq.req = 3'b001;
    wait_rsp(cyc);
    checks++; if (rq.rsp_valid !== 3'b001 || rq.rsp_c !== CW'(12)) begin errors++; $display("FAIL t3_owner: got %b/%0d expected 001/12", rq.rsp_valid, rq.rsp_c); end
    rq.req = '0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rq.gnt != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t3_pulse_ignored: got %b expected 0", seen); end
    set_op(2, 3, 2);
    rq.req = 3'b100;
    wait_gnt(cyc);
    checks++; if (rq.gnt !== 3'b100) begin errors++; $display("FAIL t3_gnt2: got %b expected 100", rq.gnt); end
    wait_rsp(cyc);
    checks++; if (rq.rsp_valid !== 3'b100 || rq.rsp_c !== CW'(5)) begin errors++; $display("FAIL t3_rsp2: got %b/%0d expected 100/5", rq.rsp_valid, rq.rsp_c); end
    rq.req = '0;
    @(negedge clk);
  endtask
  task automatic test_same_cycle();
    int cyc;
    set_op(0, 'h40, 15);
    rq.req = 3'b001;
    wait_gnt(cyc);
    @(negedge clk);
    wait_rsp(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL t6_latency: got %0d expected 16", cyc); end
    checks++; if (rq.rsp_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL t6_err: got %b/%b expected 0/0", rq.rsp_err, timeout_err); end
    checks++; if (rq.rsp_c !== CW'('h4F)) begin errors++; $display("FAIL t6_data: got %0h expected 4f", rq.rsp_c); end
    rq.req = '0;
    @(negedge clk);
  endtask
  task automatic test_timeout();
    int cyc;
    never_done = 1'b1;
    set_op(1, 'h55, 3);
    rq.req = 3'b010;
    wait_gnt(cyc);
    @(negedge clk);
    wait_rsp(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL t4_latency: got %0d expected 16", cyc); end
    checks++; if (rq.rsp_valid !== 3'b010 || rq.rsp_err !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL t4_err: got %b/%b/%b expected 010/1/1", rq.rsp_valid, rq.rsp_err, timeout_err); end
    checks++; if ({rq.rsp_c, rq.rsp_r} !== '0) begin errors++; $display("FAIL t4_zero_data: got %0h expected 0", {rq.rsp_c, rq.rsp_r}); end
    rq.req = '0;
    never_done = 1'b0;
    @(negedge clk);
    set_op(2, 9, 2);
    rq.req = 3'b100;
    wait_gnt(cyc);
    wait_rsp(cyc);
    checks++; if (rq.rsp_err !== 1'b0 || rq.rsp_c !== CW'(11) || timeout_err !== 1'b1) begin errors++; $display("FAIL t4_next_job: got %b/%0d/%b expected 0/11/1", rq.rsp_err, rq.rsp_c, timeout_err); end
    rq.req = '0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int cyc;
    logic seen;
    set_op(0, 5, 1);
    rq.req = 3'b001;
    wait_gnt(cyc);
    wait_rsp(cyc);
    rq.req = '0;
    @(negedge clk);
    set_op(1, 2, 10);
    rq.req = 3'b010;
    wait_gnt(cyc);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({rq.gnt, rq.rsp_valid} !== 6'b0) begin errors++; $display("FAIL t5_clear: got %b expected 0", {rq.gnt, rq.rsp_valid}); end
    checks++; if ({busy, timeout_err, p_reset, p_en} !== 4'b0010) begin errors++; $display("FAIL t5_status: got %b expected 0010", {busy, timeout_err, p_reset, p_en}); end
    reset = 1'b0;
    rq.req = '0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rq.rsp_valid != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t5_no_rsp: got %b expected 0", seen); end
    set_op(0, 20, 3);
    rq.req = 3'b011;
    wait_gnt(cyc);
    checks++; if (rq.gnt !== 3'b001) begin errors++; $display("FAIL t5_ptr_reset: got %b expected 001", rq.gnt); end
    wait_rsp(cyc);
    checks++; if (rq.rsp_valid !== 3'b001 || rq.rsp_c !== CW'(23) || rq.rsp_err !== 1'b0) begin errors++; $display("FAIL t5_fresh_job: got %b/%0d/%b expected 001/23/0", rq.rsp_valid, rq.rsp_c, rq.rsp_err); end
    rq.req = '0;
    @(negedge clk);
  endtask
  initial begin
    rq.req = '0;
    rq.req_c = '0;
    rq.req_rounds = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pulse();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
